// File: rtl/fifo_drain_tx.sv
// Pops bytes from the byte-wide synchronous FIFO and sends each one on a UART-style line.
// Frame format: 1 start bit, 8 data bits LSB-first, 1 stop bit. No parity.
module fifo_drain_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic [7:0] sent_cnt
);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       sent_q, sent_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             pop;
    logic             bit_end;

    // Pop only from IDLE and never while reset is held, so a held reset cannot strand a byte.
    assign pop     = rst && (state_q == IDLE) && en && !fifo_empty;
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sent_d  = sent_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (pop) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                // The FIFO presents read data one cycle after the pop strobe.
                shreg_d = fifo_dout;
                state_d = START;
                tx_d    = 1'b0;
                cnt_d   = '0;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sent_d  = sent_q + 8'd1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            sent_q  <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sent_q  <= sent_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign fifo_rd  = pop;
    assign tx       = tx_q;
    // busy covers the pop cycle itself as well as the registered frame period.
    assign busy     = busy_q | pop;
    assign sent_cnt = sent_q;

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Scoreboard bench for fifo_drain_tx: a FIFO model feeds bytes, a monitor decodes tx frames.
module tb_fifo_drain_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'd0;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic [7:0] sent_cnt;

    int errors = 0;
    int total  = 0;

    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic [7:0] exp_q [$];

    int pops = 0;
    int frames_seen = 0;
    int last_gap = 0;

    fifo_drain_tx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .tx(tx), .busy(busy),
        .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: registered read data, valid the cycle after the pop strobe.
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_dout <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Monitor: decodes every tx frame and compares it with the expected byte queue.
    logic s [0:10*CPB-1];
    int   n = 0;
    bit   in_frame = 0;
    bit   have_prev = 0;
    int   idle_run = 0;

    always @(negedge clk) begin
        if (fifo_rd) begin
            pops++;
            check("rd_while_empty", int'(fifo_empty), 0);
        end
        if (!rst) begin
            if (in_frame && exp_q.size() > 0) void'(exp_q.pop_front());
            in_frame  = 0;
            have_prev = 0;
            idle_run  = 0;
        end else begin
            if (!in_frame && tx == 1'b0) begin
                in_frame = 1;
                n = 0;
                if (have_prev) check("min_gap", int'(idle_run >= 2), 1);
                last_gap = idle_run;
            end
            if (in_frame) begin
                s[n] = tx;
                n++;
                if (n == 10*CPB) begin
                    bit   shape_ok;
                    logic [7:0] b;
                    shape_ok = (s[0] == 1'b0) && (s[9*CPB] == 1'b1);
                    for (int k = 0; k < 10*CPB; k++)
                        if (s[k] != s[(k / CPB) * CPB]) shape_ok = 0;
                    for (int i = 0; i < 8; i++) b[i] = s[(i+1)*CPB + CPB/2];
                    check("frame_shape", int'(shape_ok), 1);
                    if (exp_q.size() == 0) check("unexpected_frame", int'(b), -1);
                    else check("frame_byte", int'(b), int'(exp_q.pop_front()));
                    frames_seen++;
                    in_frame  = 0;
                    have_prev = 1;
                    idle_run  = 0;
                end
            end else if (tx) begin
                idle_run++;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        exp_q.push_back(b);
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input string name);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_rd) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check(name, 0, 1);
    endtask

    task automatic wait_frames(input string name, input int target, input int limit);
        int i = 0;
        while (frames_seen < target && i < limit) begin
            @(negedge clk);
            i++;
        end
        check(name, frames_seen, target);
    endtask

    int a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        int busy_cycles;
        int base;

        // Reset then idle with an empty FIFO.
        en  = 1'b1;
        rst = 1'b0;
        repeat (3) drive_step();
        rst = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("idle_tx", int'(tx), 1);
            check("idle_busy", int'(busy), 0);
            check("idle_rd", int'(fifo_rd), 0);
            check("idle_cnt", int'(sent_cnt), 0);
        end

        // Single byte 0xA5, per-cycle line check.
        drive_step();
        push_byte(8'hA5);
        wait_rd("a5_pop");
        busy_cycles = 0;
        for (int k = 0; k < 60; k++) begin
            if (busy) busy_cycles++;
            if (k < 42) check("a5_tx", int'(tx), (k < 2) ? 1 : a5_bits[(k-2)/CPB]);
            @(negedge clk);
        end
        check("a5_busy_len", busy_cycles, 42);
        check("a5_sent", int'(sent_cnt), 1);
        check("a5_pops", pops, 1);

        // Back-to-back frames.
        drive_step();
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        wait_frames("b2b_frames", 4, 400);
        repeat (10) @(negedge clk);
        check("b2b_pops", pops, 4);
        check("b2b_gap", last_gap, 2);
        check("b2b_sent", int'(sent_cnt), 4);

        // Enable dropped during the DATA bits of the first of two queued bytes.
        drive_step();
        en = 1'b0;
        push_byte(8'h81);
        push_byte(8'h42);
        drive_step();
        en = 1'b1;
        wait_rd("gate_pop");
        repeat (15) drive_step();
        en = 1'b0;
        wait_frames("gate_first", 5, 200);
        repeat (60) @(negedge clk);
        check("gate_pops", pops, 5);
        check("gate_sent", int'(sent_cnt), 5);
        check("gate_busy", int'(busy), 0);
        check("gate_pending", int'(fifo_empty), 0);
        drive_step();
        en = 1'b1;
        wait_frames("gate_second", 6, 200);
        repeat (5) @(negedge clk);
        check("gate_sent2", int'(sent_cnt), 6);
        check("gate_pops2", pops, 6);

        // Reset during data bit 3 of 0x5A; 0x96 follows after release.
        drive_step();
        en = 1'b0;
        push_byte(8'h5A);
        push_byte(8'h96);
        drive_step();
        en = 1'b1;
        wait_rd("rst_pop");
        base = frames_seen;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_sent", int'(sent_cnt), 0);
        check("rst_rd", int'(fifo_rd), 0);
        drive_step();
        rst = 1'b1;
        wait_frames("rst_next", base + 1, 200);
        repeat (5) @(negedge clk);
        check("rst_next_sent", int'(sent_cnt), 1);
        check("rst_pops", pops, 8);

        // Counter wrap over 256 frames.
        drive_step();
        rst = 1'b0;
        repeat (2) drive_step();
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 256; i++) push_byte(8'(i * 7 + 3));
        drive_step();
        en = 1'b1;
        base = frames_seen;
        wait_frames("wrap_255", base + 255, 12000);
        repeat (2) @(negedge clk);
        check("wrap_cnt255", int'(sent_cnt), 255);
        wait_frames("wrap_256", base + 256, 200);
        repeat (2) @(negedge clk);
        check("wrap_cnt0", int'(sent_cnt), 0);
        check("wrap_pops", pops, 8 + 256);
        repeat (50) @(negedge clk);
        check("wrap_no_stray", pops, 8 + 256);
        check("wrap_empty", int'(fifo_empty), 1);
        check("wrap_exp_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule

// File: doc/fifo_drain_tx.md
Name: fifo_drain_tx

Overview:
Read-side consumer for the team's byte-wide synchronous FIFO. It pops one byte at a time from the FIFO and serializes it onto a single-wire, UART-style line. The frame is 1 start bit, 8 data bits LSB-first and 1 stop bit. It sits between the FIFO output (dout/rd) and the chip-level serial pin.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..255.
CNT_W, 8, width of the baud counter; must hold CLKS_PER_BIT-1.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset; synchronous, active-low (rst=0 sampled at a rising edge resets the block).
en  input  1  drain enable; when 0, no new byte is popped.
fifo_empty  input  1  FIFO has no readable data.
fifo_dout  input  8  FIFO read data; registered in the FIFO, valid the cycle after fifo_rd.
fifo_rd  output  1  one-cycle pop strobe to the FIFO.
tx  output  1  serial line, idle high, registered.
busy  output  1  high from the pop cycle through the last stop-bit cycle.
sent_cnt  output  8  count of completed frames, wraps 255->0.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, tx=1, busy=0, sent_cnt=0, shift register=0, counters=0. fifo_rd is 0 while state=IDLE and the block is in reset.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - fifo_rd = en & ~fifo_empty (combinational, IDLE only; 0 in every other state).
  - If fifo_rd=1 -> LOAD at next edge, busy=1 from that edge.
  - tx=1.
- LOAD (exactly 1 cycle):
  - The shift register captures fifo_dout.
  - Next state START; tx driven 0 from this edge.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx=shreg[0] for CLKS_PER_BIT cycles per bit; shift right at each bit boundary.
  - A 3-bit bit index counts 0..7; after bit 7 the next state is STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the last stop cycle edge: sent_cnt+=1, busy=0, state=IDLE.
- Latency:
  - fifo_rd cycle = cycle 0; tx falls at the edge ending cycle 1.
  - Frame occupies exactly 10*CLKS_PER_BIT cycles of tx.
  - Back-to-back frames have a minimum of 2 cycles of tx=1 between stop end and next start (IDLE + LOAD).
- Baud counter: counts 0..CLKS_PER_BIT-1, cleared on every state entry. No fractional baud.
- en deasserted mid-frame: the current frame completes unchanged; no further pop.
- fifo_empty rising mid-frame: ignored; it is sampled only in IDLE.
- Exactly one pop per frame; fifo_rd never asserts twice without an intervening frame.
- Reset mid-frame: tx=1 at the reset edge, frame aborted, the popped byte is discarded, and sent_cnt is not incremented.
- sent_cnt wraps 255->0 with no flag.
- No pop is ever issued while fifo_empty=1, even with en=1.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release with fifo_empty=1, en=1 -> tx=1, busy=0, fifo_rd=0, sent_cnt=0 for 50 cycles.
- Single byte, CLKS_PER_BIT=4: FIFO holds 0xA5, en=1 -> one fifo_rd pulse. tx falls 2 cycles later, then 4-cycle bits in the order start 0, data 1,0,1,0,0,1,0,1, stop 1. busy is high for 42 cycles and sent_cnt=1.
- Back-to-back: FIFO holds 0x00,0xFF,0x3C -> 3 frames, exactly 3 fifo_rd pulses, 2-cycle idle gaps, decoded bytes match in order, sent_cnt=3.
- Enable gating: drop en in the middle of the DATA bits of the first of two queued bytes -> the first frame finishes intact, no second pop. Raising en later triggers the second frame.
- Reset mid-frame: assert rst=0 during bit 3 of frame 0x5A -> tx=1 at the reset edge, busy=0, sent_cnt unchanged at 0. The next queued byte is sent cleanly after release.
- Counter wrap: send 256 frames -> sent_cnt reads 0 after the 256th stop bit, with no stray fifo_rd.
